div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values 8..64.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  high only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  dividend.
REQ-007 SHALL have port b  input  WIDTH  divisor.
REQ-008 SHALL have port sign  input  1  1 = two's-complement signed, 0 = unsigned.
REQ-009 SHALL have port cancel  input  1  abort the in-flight operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port quotient  output  WIDTH  quotient.
REQ-013 SHALL have port remainder  output  WIDTH  remainder.
REQ-014 SHALL have port div_by_zero  output  1  qualifies the result as b==0.
REQ-015 SHALL have port busy  output  1  high in CALC or DONE (pipeline stall).

Function
REQ-016 SHALL implement states IDLE, CALC, DONE.
REQ-017 SHALL accept an operation when in_valid & in_ready at a clock edge; a, b and sign are captured at that edge.
REQ-018 SHALL go IDLE->CALC on accept with b!=0, and IDLE->DONE on accept with b==0.
REQ-019 SHALL use radix-2 restoring division on magnitudes: WIDTH+1-bit trial subtract per CALC cycle, one quotient bit per cycle.
REQ-020 SHALL spend exactly WIDTH cycles in CALC (macro off), then enter DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-021 SHALL hold out_valid, quotient, remainder and div_by_zero stable in DONE until out_valid & out_ready, then go to IDLE.
REQ-022 SHALL give signed results as: quotient negated iff a and b signs differ; remainder takes the sign of a.
REQ-023 SHALL produce, for b==0: quotient all ones, remainder = a, div_by_zero=1, out_valid one cycle after accept.
REQ-024 SHALL produce, for signed MIN/-1: quotient = MIN, remainder = 0, with no flag.
REQ-025 SHALL make cancel in CALC or DONE go to IDLE at the next edge with out_valid low, and SHALL ignore cancel in IDLE; cancel wins over out_ready.
REQ-026 SHALL ignore in_valid while not in IDLE.

Reset
REQ-027 SHALL, on rst asserted: go to IDLE and clear out_valid, busy, div_by_zero, quotient, remainder and the counter to 0, with in_ready=1; this holds mid-operation too, and the operation is discarded.

Configuration
REQ-028 SHALL, with DIV_SEQ_EARLY_EXIT_EN defined: pre-shift the dividend magnitude by its leading-zero count L at accept and run WIDTH-L CALC cycles, with a minimum of 1 (a==0 takes 1 cycle); results SHALL be identical to macro-off.
REQ-029 SHALL, without DIV_SEQ_EARLY_EXIT_EN: use fixed WIDTH-cycle CALC, and SHALL instantiate no leading-zero logic.

Structure
REQ-030 SHALL take the state enum type and the result sign-fixup function from shared package div_pkg.
REQ-031 SHALL put leading-zero counting in sub-module div_lzc (parameter WIDTH), instantiated only under DIV_SEQ_EARLY_EXIT_EN.
REQ-032 SHALL keep a single combinational subtract/mux datapath with shift register and counter in div_seq.

Verification
REQ-033 Unsigned, WIDTH=32, a=100, b=7, out_ready=1 -> quotient=14, remainder=2, out_valid 33 cycles after accept (macro off).
REQ-034 Signed, a=-7, b=2 -> quotient=-3 (0xFFFFFFFD), remainder=-1; a=0x80000000, b=-1 -> quotient=0x80000000, remainder=0.
REQ-035 b=0, a=0x1234 -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x1234, out_valid 1 cycle after accept.
REQ-036 out_ready held low 5 cycles after out_valid -> outputs stable; in_valid pulses are ignored; IDLE follows the edge where out_ready=1.
REQ-037 cancel at CALC cycle 10, then rst mid-CALC -> IDLE next edge / immediately, out_valid never asserted, next op correct.
REQ-038 Macro on, unsigned a=5, b=2 -> quotient=2, remainder=1 in 3 CALC cycles; random 10k-vector compare against a reference model, both macro settings.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
// Provides the FSM state type and the result sign fix-up function.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DIV_MAXW = 64;

  // Applies a two's-complement negate to a magnitude when requested.
  // Callers truncate the result to their own width.
  function automatic logic [DIV_MAXW-1:0] fix_sign(
    input logic [DIV_MAXW-1:0] mag,
    input logic                neg
  );
    return neg ? (~mag + 64'd1) : mag;
  endfunction

endpackage

// File: rtl/div_lzc.sv
// Leading-zero counter for the divider's early-exit pre-shift.
// Ports: i_val (WIDTH) value in, o_cnt leading zeros (WIDTH if zero).
module div_lzc
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             i_val,
  output logic [$clog2(WIDTH+1)-1:0]   o_cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_val[i]) o_cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_seq.sv
// Radix-2 restoring sequential divider, signed or unsigned, with cancel.
// Ports: clk, rst (async high); in_valid/in_ready, a, b, sign, cancel;
// out_valid/out_ready, quotient, remainder, div_by_zero, busy.
// Macro DIV_SEQ_EARLY_EXIT_EN: skip leading-zero dividend bits.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;

  logic             w_idle;
  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_a_init;
  logic [CW-1:0]    w_cnt_init;
  logic [WIDTH:0]   w_part;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic             w_last;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = in_valid & w_idle;
  assign w_a_neg  = sign & a[WIDTH-1];
  assign w_b_neg  = sign & b[WIDTH-1];
  assign w_b_zero = (b == '0);
  assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

`ifdef DIV_SEQ_EARLY_EXIT_EN
  logic [CW-1:0] w_lz;

  div_lzc #(
    .WIDTH (WIDTH)
  ) u_lzc (
    .i_val (w_a_mag),
    .o_cnt (w_lz)
  );

  // Leading zeros would only shift zero quotient bits in, so skip them.
  // A zero dividend still takes one pass to leave a clean remainder.
  assign w_a_init   = w_a_mag << w_lz;
  assign w_cnt_init = (w_lz == CW'(WIDTH)) ? CW'(1)
                                           : CW'(WIDTH) - w_lz;
`else
  assign w_a_init   = w_a_mag;
  assign w_cnt_init = CW'(WIDTH);
`endif

  // Partial remainder is always below twice the divisor, so WIDTH+1
  // bits hold it and the top bit of the difference is the borrow.
  assign w_part   = {r_rem, r_quo[WIDTH-1]};
  assign w_sub    = w_part - {1'b0, r_div};
  assign w_ge     = ~w_sub[WIDTH];
  assign w_rem_nx = w_ge ? w_sub[WIDTH-1:0] : w_part[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
  assign w_last   = (r_cnt == CW'(1));

  assign w_q_fix = WIDTH'(fix_sign(DIV_MAXW'(w_quo_nx), r_neg_q));
  assign w_r_fix = WIDTH'(fix_sign(DIV_MAXW'(w_rem_nx), r_neg_r));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div   <= w_b_mag;
            r_rem   <= '0;
            r_quo   <= w_a_init;
            r_cnt   <= w_cnt_init;
            r_dbz   <= w_b_zero;
            if (w_b_zero) begin
              r_q_out <= '1;
              r_r_out <= a;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (cancel) begin
            r_state <= ST_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
              r_q_out <= w_q_fix;
              r_r_out <= w_r_fix;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (cancel | out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = w_idle;
  assign busy        = ~w_idle;
  assign out_valid   = (r_state == ST_DONE);
  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dbz;

endmodule
